// File: rtl/obi_target_demux_if.sv
// OBI bus bundle for the target demux: one upstream port plus N_TGT flattened downstream ports.
// slave is the demux view; master is the view of whatever drives it (initiator and targets).
`timescale 1ns/1ps
interface obi_target_demux_if #(
    parameter int unsigned N_TGT = 4
);
    logic                  s_req_i;
    logic                  s_we_i;
    logic [3:0]            s_be_i;
    logic [31:0]           s_addr_i;
    logic [31:0]           s_wdata_i;
    logic                  s_gnt_o;
    logic                  s_rvalid_o;
    logic [31:0]           s_rdata_o;
    logic                  s_err_o;

    logic [N_TGT-1:0]      m_req_o;
    logic [N_TGT-1:0]      m_we_o;
    logic [4*N_TGT-1:0]    m_be_o;
    logic [32*N_TGT-1:0]   m_addr_o;
    logic [32*N_TGT-1:0]   m_wdata_o;
    logic [N_TGT-1:0]      m_gnt_i;
    logic [N_TGT-1:0]      m_rvalid_i;
    logic [32*N_TGT-1:0]   m_rdata_i;

    modport slave (
        input  s_req_i, s_we_i, s_be_i, s_addr_i, s_wdata_i,
        output s_gnt_o, s_rvalid_o, s_rdata_o, s_err_o,
        output m_req_o, m_we_o, m_be_o, m_addr_o, m_wdata_o,
        input  m_gnt_i, m_rvalid_i, m_rdata_i
    );

    modport master (
        output s_req_i, s_we_i, s_be_i, s_addr_i, s_wdata_i,
        input  s_gnt_o, s_rvalid_o, s_rdata_o, s_err_o,
        input  m_req_o, m_we_o, m_be_o, m_addr_o, m_wdata_o,
        output m_gnt_i, m_rvalid_i, m_rdata_i
    );
endinterface

// File: rtl/obi_target_demux.sv
// OBI 1-to-N address demux. An in-order FIFO of {unmapped, sel} routes responses back
// in grant order; unmapped accesses are self-granted and answered with an error beat.
`timescale 1ns/1ps
module obi_target_demux #(
    parameter int unsigned N_TGT      = 4,
    parameter int unsigned SEL_LSB    = 20,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned ADDR_SHIFT = 2,
    parameter int unsigned MAX_OUT    = 4,
    parameter logic [31:0] ERR_RDATA  = 32'hBADCAB1E
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    obi_target_demux_if.slave      bus,
    output logic                   proto_err_o
);
    localparam int unsigned PTR_W   = $clog2(MAX_OUT);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned SEL_N   = 2 ** SEL_W;
    // One bit per encodable select value, set for the ones that map to a real target.
    localparam logic [SEL_N-1:0] MAP_MASK = {SEL_N{1'b1}} >> (SEL_N - N_TGT);

    logic [SEL_W-1:0]  w_sel;
    logic              w_unmapped;
    logic [31:0]       w_fwd_addr;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [SEL_W-1:0]  w_head_sel;
    logic              w_head_unm;
    logic [N_TGT-1:0]  w_expect;
    logic              w_stray;

    logic [SEL_W-1:0]  r_fifo_sel [MAX_OUT];
    logic [MAX_OUT-1:0] r_fifo_unm;
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_proto_err;

    assign w_sel      = bus.s_addr_i[SEL_LSB +: SEL_W];
    assign w_unmapped = ~MAP_MASK[w_sel];
    assign w_fwd_addr = bus.s_addr_i >> ADDR_SHIFT;
    assign w_full     = (r_count == CNT_W'(MAX_OUT));
    assign w_empty    = (r_count == '0);
    assign w_push     = bus.s_req_i & bus.s_gnt_o;
    assign w_head_sel = r_fifo_sel[r_rptr];
    assign w_head_unm = r_fifo_unm[r_rptr];

    // Request path: purely combinational, gated off entirely while the FIFO is full.
    always_comb begin
        bus.m_req_o   = '0;
        bus.m_we_o    = '0;
        bus.m_be_o    = '0;
        bus.m_addr_o  = '0;
        bus.m_wdata_o = '0;
        bus.s_gnt_o   = 1'b0;
        if (!w_full) begin
            if (w_unmapped) begin
                bus.s_gnt_o = bus.s_req_i;
            end else begin
                for (int k = 0; k < N_TGT; k++) begin
                    if (w_sel == SEL_W'(k)) begin
                        bus.m_req_o[k]           = bus.s_req_i;
                        bus.m_we_o[k]            = bus.s_we_i;
                        bus.m_be_o[4*k +: 4]     = bus.s_be_i;
                        bus.m_addr_o[32*k +: 32] = w_fwd_addr;
                        bus.m_wdata_o[32*k +: 32] = bus.s_wdata_i;
                        bus.s_gnt_o              = bus.m_gnt_i[k];
                    end
                end
            end
        end
    end

    // Response path: only the head entry's target may deliver; anything else is a stray.
    always_comb begin
        bus.s_rvalid_o = 1'b0;
        bus.s_rdata_o  = '0;
        bus.s_err_o    = 1'b0;
        w_pop          = 1'b0;
        w_expect       = '0;
        if (!w_empty) begin
            if (w_head_unm) begin
                bus.s_rvalid_o = 1'b1;
                bus.s_rdata_o  = ERR_RDATA;
                bus.s_err_o    = 1'b1;
                w_pop          = 1'b1;
            end else begin
                for (int k = 0; k < N_TGT; k++) begin
                    if (w_head_sel == SEL_W'(k)) begin
                        w_expect[k]    = 1'b1;
                        bus.s_rvalid_o = bus.m_rvalid_i[k];
                        bus.s_rdata_o  = bus.m_rdata_i[32*k +: 32];
                        w_pop          = bus.m_rvalid_i[k];
                    end
                end
            end
        end
    end

    assign w_stray = |(bus.m_rvalid_i & ~w_expect);

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo_sel[r_wptr] <= w_sel;
            r_fifo_unm[r_wptr] <= w_unmapped;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_stray) r_proto_err <= 1'b1;
        end
    end

    assign proto_err_o = r_proto_err;
endmodule

// File: doc/obi_target_demux.md
OBI_TARGET_DEMUX -- requirements
Module: obi_target_demux

Interface
REQ-001 SHALL have parameter N_TGT, default 4, number of downstream targets (1..16).
REQ-002 SHALL have parameter SEL_LSB, default 20, lowest address bit of target-select field.
REQ-003 SHALL have parameter SEL_W, default 2, target-select field width; 2**SEL_W >= N_TGT.
REQ-004 SHALL have parameter ADDR_SHIFT, default 2, right shift applied to forwarded address (byte to word).
REQ-005 SHALL have parameter MAX_OUT, default 4, maximum outstanding transactions (power of two, >=2).
REQ-006 SHALL have parameter ERR_RDATA, default 32'hBADCAB1E, rdata returned for unmapped accesses.
REQ-007 CLK  in  1  clock; RSTN  in  1  reset, asynchronous, active-low.
REQ-008 s_req_i in 1, s_we_i in 1, s_be_i in 4, s_addr_i in 32, s_wdata_i in 32: upstream OBI request.
REQ-009 s_gnt_o out 1, s_rvalid_o out 1, s_rdata_o out 32, s_err_o out 1: upstream OBI response.
REQ-010 m_req_o out N_TGT, m_we_o out N_TGT, m_be_o out 4*N_TGT, m_addr_o out 32*N_TGT, m_wdata_o out 32*N_TGT: per-target request.
REQ-011 m_gnt_i in N_TGT, m_rvalid_i in N_TGT, m_rdata_i in 32*N_TGT: per-target response.
REQ-012 proto_err_o out 1: sticky flag, rvalid from a target not at queue head.

Function
REQ-013 sel = s_addr_i[SEL_LSB+SEL_W-1:SEL_LSB]; sel >= N_TGT is unmapped.
REQ-014 Mapped, queue not full: m_req_o[sel]=s_req_i; m_we/be/wdata[sel] = upstream; m_addr_o[sel] = s_addr_i >> ADDR_SHIFT; all other targets' fields 0; s_gnt_o = m_gnt_i[sel]; combinational, zero latency.
REQ-015 Queue full (MAX_OUT entries): all m_req_o=0 and s_gnt_o=0 regardless of sel.
REQ-016 Unmapped, queue not full: no m_req_o asserted; s_gnt_o = s_req_i (self-grant).
REQ-017 Handshake (s_req_i && s_gnt_o) SHALL push {unmapped flag, sel} into a FIFO of depth MAX_OUT.
REQ-018 Response routing: if head entry mapped, s_rvalid_o = m_rvalid_i[head.sel], s_rdata_o = m_rdata_i[head.sel], s_err_o=0; pop when that rvalid=1.
REQ-019 If head entry unmapped: s_rvalid_o=1, s_rdata_o=ERR_RDATA, s_err_o=1 for exactly one cycle; pop that cycle; earliest is the cycle after its grant.
REQ-020 Responses SHALL be returned strictly in grant order; targets complete in order per target.
REQ-021 Queue empty: s_rvalid_o=0, s_rdata_o=0, s_err_o=0.
REQ-022 Simultaneous push and pop SHALL keep occupancy unchanged; push while full impossible by REQ-015; pop at full re-enables grant next cycle, not same cycle.
REQ-023 Read/write pointers SHALL wrap modulo MAX_OUT; occupancy counter width clog2(MAX_OUT)+1.
REQ-024 m_rvalid_i[k]=1 with queue empty or head.sel != k SHALL set proto_err_o next cycle, held until reset; rvalid ignored.
REQ-025 Write transactions SHALL also occupy a queue entry and expect a target rvalid.

Reset
REQ-026 RSTN low SHALL asynchronously clear FIFO pointers, occupancy and proto_err_o; s_rvalid_o, s_err_o=0, s_rdata_o=0.
REQ-027 Reset mid-transaction SHALL discard all outstanding entries; late target rvalid after reset sets proto_err_o.
REQ-028 During reset s_gnt_o follows combinational rules with queue empty.

Verification
REQ-029 Read addr 0x0010_0008, target1 gnt same cycle, rvalid+rdata 0x1234 two cycles later -> m_addr_o[1]=0x0004_0002, s_rvalid_o=1, s_rdata_o=0x1234, s_err_o=0.
REQ-030 4 back-to-back grants to targets 0,1,2,3 with no rvalid, 5th request -> s_gnt_o=0, all m_req_o=0; one rvalid from target0 -> grant resumes next cycle.
REQ-031 N_TGT=3, addr 0x0030_0000 -> no m_req_o, s_gnt_o=1, next cycle s_rvalid_o=1, s_rdata_o=0xBADCAB1E, s_err_o=1.
REQ-032 Grant target2 then target0; target0 rvalid first -> proto_err_o=1, no upstream rvalid; target2 rvalid then delivered.
REQ-033 Simultaneous push and pop at occupancy 2 over 50 random cycles -> occupancy and ordering match scoreboard.
REQ-034 Assert RSTN low with 3 outstanding -> queue empty, s_rvalid_o=0, proto_err_o=0 after release.
